// File: rtl/port_host_pkg.sv
// Shared definitions for the host-side I/O port driver: word width and TX FSM states.
package port_host_pkg;

   localparam int unsigned PORT_W = 16;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_DRIVE = 2'd1,
      TX_GAP   = 2'd2
   } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with an extra count bit so that full and empty never alias.
module sync_fifo #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [AW:0]    count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic           push_ok;
   logic           pop_ok;

   assign empty = (count_q == {(AW+1){1'b0}});
   assign full  = (count_q == (AW+1)'(DEPTH));
   assign rdata = empty ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];

   // A push into a full FIFO is still accepted when the same edge pops an entry.
   always_comb begin
      pop_ok   = pop && !empty;
      push_ok  = push && (!full || pop_ok);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         count_q  <= {(AW+1){1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

endmodule

// File: rtl/port_host.sv
// Host driver for the computer's 16-bit I/O port: strobes queued words into port_in and
// captures every change seen on port_out into a buffered stream.
module port_host
   import port_host_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned HOLD  = 2,
   parameter int unsigned GAP   = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              tx_valid,
   input  logic [PORT_W-1:0] tx_data,
   output logic              tx_ready,
   output logic [PORT_W-1:0] port_in,
   output logic              port_write,
   input  logic [PORT_W-1:0] port_out,
   output logic              rx_valid,
   output logic [PORT_W-1:0] rx_data,
   input  logic              rx_ready,
   output logic              rx_overflow,
   output logic              busy
);

   localparam int unsigned CNT_W = 16;

   tx_state_e         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [PORT_W-1:0] port_in_q, port_in_d;
   logic              port_write_q, port_write_d;
   logic [PORT_W-1:0] prev_q, prev_d;
   logic              overflow_q, overflow_d;

   logic              tx_full, tx_empty, tx_push, tx_pop;
   logic [PORT_W-1:0] tx_rdata;
   logic              rx_full, rx_empty, rx_push, rx_pop;

   assign tx_push = tx_valid && !tx_full;
   assign tx_ready = !tx_full;

   sync_fifo #(.WIDTH(PORT_W), .DEPTH(DEPTH)) u_tx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (tx_push),
      .wdata (tx_data),
      .pop   (tx_pop),
      .rdata (tx_rdata),
      .full  (tx_full),
      .empty (tx_empty)
   );

   // TX FSM: one IDLE cycle, HOLD cycles of strobe, GAP cycles low.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      port_in_d    = port_in_q;
      port_write_d = 1'b0;
      tx_pop       = 1'b0;
      case (state_q)
         TX_IDLE: begin
            if (!tx_empty) begin
               tx_pop       = 1'b1;
               port_in_d    = tx_rdata;
               port_write_d = 1'b1;
               cnt_d        = CNT_W'(HOLD - 1);
               state_d      = TX_DRIVE;
            end else begin
               state_d = TX_IDLE;
            end
         end
         TX_DRIVE: begin
            if (cnt_q == {CNT_W{1'b0}}) begin
               cnt_d   = CNT_W'(GAP - 1);
               state_d = TX_GAP;
            end else begin
               cnt_d        = cnt_q - CNT_W'(1);
               port_write_d = 1'b1;
            end
         end
         TX_GAP: begin
            if (cnt_q == {CNT_W{1'b0}}) begin
               state_d = TX_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = TX_IDLE;
            cnt_d   = {CNT_W{1'b0}};
         end
      endcase
   end

   assign rx_pop  = !rx_empty && rx_ready;
   assign rx_push = (port_out != prev_q);

   sync_fifo #(.WIDTH(PORT_W), .DEPTH(DEPTH)) u_rx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (rx_push),
      .wdata (port_out),
      .pop   (rx_pop),
      .rdata (rx_data),
      .full  (rx_full),
      .empty (rx_empty)
   );

   // A change is lost only when the RX FIFO is full and nothing leaves it on the same edge.
   always_comb begin
      prev_d = port_out;
      if (rx_push && rx_full && !rx_pop) begin
         overflow_d = 1'b1;
      end else begin
         overflow_d = overflow_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= TX_IDLE;
         cnt_q        <= {CNT_W{1'b0}};
         port_in_q    <= {PORT_W{1'b0}};
         port_write_q <= 1'b0;
         prev_q       <= {PORT_W{1'b0}};
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         port_in_q    <= port_in_d;
         port_write_q <= port_write_d;
         prev_q       <= prev_d;
         overflow_q   <= overflow_d;
      end
   end

   assign port_in     = port_in_q;
   assign port_write  = port_write_q;
   assign rx_valid    = !rx_empty;
   assign rx_overflow = overflow_q;
   assign busy        = !tx_empty || (state_q != TX_IDLE);

endmodule

// File: tb/tb_port_host.sv
// Randomized bench for port_host against a schedule-level model of strobes and a change-capture queue.
module tb_port_host;

   localparam int DEPTH = 8;
   localparam int HOLD  = 2;
   localparam int GAP   = 1;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        tx_valid = 1'b0;
   logic [15:0] tx_data = 16'h0000;
   logic        tx_ready;
   logic [15:0] port_in;
   logic        port_write;
   logic [15:0] port_out = 16'h0000;
   logic        rx_valid;
   logic [15:0] rx_data;
   logic        rx_ready = 1'b0;
   logic        rx_overflow;
   logic        busy;

   port_host #(.DEPTH(DEPTH), .HOLD(HOLD), .GAP(GAP)) dut (
      .clk         (clk),
      .reset       (reset),
      .tx_valid    (tx_valid),
      .tx_data     (tx_data),
      .tx_ready    (tx_ready),
      .port_in     (port_in),
      .port_write  (port_write),
      .port_out    (port_out),
      .rx_valid    (rx_valid),
      .rx_data     (rx_data),
      .rx_ready    (rx_ready),
      .rx_overflow (rx_overflow),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state: words waiting to be strobed, captured values, strobe schedule.
   logic [15:0] txq[$];
   logic [15:0] rxq[$];
   logic [15:0] m_prev = 16'h0000;
   logic [15:0] m_port_in = 16'h0000;
   bit          m_ovf = 1'b0;
   bit          m_started = 1'b0;
   int          m_last_start = 0;
   int          m_next_allowed = 0;
   int          edge_no = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edge_no, obs, exp);
      end
   endtask

   task automatic step(input logic rst, input logic tv, input logic [15:0] td,
                       input logic [15:0] po, input logic rr);
      int size_before;
      bit exp_write;
      bit exp_busy;
      reset    = rst;
      tx_valid = tv;
      tx_data  = td;
      port_out = po;
      rx_ready = rr;
      if (rst) begin
         txq.delete();
         rxq.delete();
         m_prev = 16'h0000;
         m_port_in = 16'h0000;
         m_ovf = 1'b0;
         m_started = 1'b0;
         m_next_allowed = 0;
      end else begin
         size_before = txq.size();
         if (size_before > 0 && edge_no >= m_next_allowed) begin
            m_port_in = txq.pop_front();
            m_started = 1'b1;
            m_last_start = edge_no;
            m_next_allowed = edge_no + HOLD + GAP + 1;
         end
         if (tv && size_before < DEPTH) txq.push_back(td);
         if (rxq.size() > 0 && rr) void'(rxq.pop_front());
         if (po != m_prev) begin
            if (rxq.size() < DEPTH) rxq.push_back(po);
            else m_ovf = 1'b1;
         end
         m_prev = po;
      end
      @(posedge clk);
      #1;
      exp_write = m_started && !rst && (edge_no >= m_last_start) && (edge_no < m_last_start + HOLD);
      exp_busy  = (txq.size() > 0) || (m_started && !rst && (edge_no < m_last_start + HOLD + GAP));
      check_eq("port_write", {31'd0, port_write}, {31'd0, exp_write});
      check_eq("port_in", {16'd0, port_in}, {16'd0, m_port_in});
      check_eq("tx_ready", {31'd0, tx_ready}, {31'd0, (txq.size() < DEPTH)});
      check_eq("busy", {31'd0, busy}, {31'd0, exp_busy});
      check_eq("rx_valid", {31'd0, rx_valid}, {31'd0, (rxq.size() > 0)});
      if (rxq.size() > 0) check_eq("rx_data", {16'd0, rx_data}, {16'd0, rxq[0]});
      else if (rst) check_eq("rx_data_reset", {16'd0, rx_data}, 32'd0);
      check_eq("rx_overflow", {31'd0, rx_overflow}, {31'd0, m_ovf});
      edge_no++;
   endtask

   logic [15:0] po_cur = 16'h0000;

   initial begin
      step(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
      step(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);

      // Single word delivery
      step(1'b0, 1'b1, 16'h1234, 16'h0000, 1'b0);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);

      // Burst until the TX FIFO fills, then drain
      for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 16'(16'hA000 + i), 16'h0000, 1'b0);
      for (int i = 0; i < 45; i++) step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);

      // Change capture 0,0,5,5,5,7,7,0 then drain
      step(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
      step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0000, 16'h0005, 1'b0);
      for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 16'h0000, 16'h0007, 1'b0);
      step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);

      // Fill RX, push+pop while full, then overflow and stickiness
      step(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
      for (int i = 1; i <= 8; i++) step(1'b0, 1'b0, 16'h0000, 16'(i), 1'b0);
      step(1'b0, 1'b0, 16'h0000, 16'h0009, 1'b1);
      step(1'b0, 1'b0, 16'h0000, 16'h000A, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0000, 16'h000A, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 16'h0000, 16'h000A, 1'b1);

      // Reset during a strobe with words queued
      step(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 16'(16'hB000 + i), 16'h0000, 1'b0);
      step(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
      for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);

      // Randomized traffic on both paths, with occasional resets
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 2) == 0) po_cur = 16'($urandom_range(0, 5));
         step(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) != 0), 16'($urandom),
              po_cur, ($urandom_range(0, 3) == 0));
      end
      for (int i = 0; i < 60; i++) step(1'b0, 1'b0, 16'h0000, po_cur, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
